exu_gpr_wb_arb: RTL and testbench

//  Round-robin arbiter sharing the single GPR write port between EXU handlers
//  (ALU, LSU load return, CSR/JAL link). Each requester offers (wa, wd) on a

---
 rtl/exu_gpr_wb_arb.sv | 124 ++++++++++++
 tb/tb_exu_gpr_wb_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_gpr_wb_arb.sv
// exu_gpr_wb_arb: round-robin arbiter that shares the single GPR write port
// between EXU writeback sources (ALU, LSU load return, CSR/JAL link).
// One winner per cycle goes into a registered write stage that drives the
// GPR write port one cycle after the handshake.
// Optional feature macro: EXU_GPR_WB_BYPASS_EN adds a forwarding port
// (byp_ra / byp_hit / byp_wd) that exposes the write stage to readers.

`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif

module exu_gpr_wb_arb #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = `RV_XLEN,
  parameter int unsigned AW    = `RV_GPR_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [N_REQ*AW-1:0]   req_wa,
  input  logic [N_REQ*XLEN-1:0] req_wd,
  output logic [N_REQ-1:0]      req_rdy,
  output logic                  gpr_wen,
  output logic [AW-1:0]         gpr_wa,
  output logic [XLEN-1:0]       gpr_wd,
  output logic                  busy
`ifdef EXU_GPR_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]         byp_ra,
  output logic                  byp_hit,
  output logic [XLEN-1:0]       byp_wd
`endif
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   nxt_ptr;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic [PW:0]     sum;
  logic            hs;
  logic [AW-1:0]   sel_wa;
  logic [XLEN-1:0] sel_wd;

  // Round-robin scan starting at ptr; the first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // ptr + k can exceed N_REQ-1 by at most N_REQ-1, so one subtract wraps it
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      if (!found && req_vld[sum[PW-1:0]]) begin
        gnt[sum[PW-1:0]] = 1'b1;
        gnt_idx          = sum[PW-1:0];
        found            = 1'b1;
      end
    end
  end

  // Next pointer: one past the winner, wrapping at N_REQ-1.
  always_comb begin
    if (gnt_idx == PW'(N_REQ - 1)) begin
      nxt_ptr = '0;
    end else begin
      nxt_ptr = gnt_idx + PW'(1);
    end
  end

  // Winner's address/data mux driven by the one-hot grant.
  always_comb begin
    sel_wa = '0;
    sel_wd = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_wa = req_wa[i*AW +: AW];
        sel_wd = req_wd[i*XLEN +: XLEN];
      end
    end
  end

  // Grant is suppressed during stall or reset; handshake follows the grant.
  always_comb begin
    req_rdy = gnt & {N_REQ{~(stall | rst)}};
    hs      = found & ~stall & ~rst;
    busy    = (|req_vld) | gpr_wen;
  end

  // Write stage and round-robin pointer; x0 targets complete but never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      gpr_wen <= 1'b0;
      gpr_wa  <= '0;
      gpr_wd  <= '0;
    end else begin
      gpr_wen <= hs & (sel_wa != '0);
      if (hs) begin
        gpr_wa <= sel_wa;
        gpr_wd <= sel_wd;
        ptr    <= nxt_ptr;
      end
    end
  end

`ifdef EXU_GPR_WB_BYPASS_EN
  // Forward the in-flight write to a reader before it lands in the GPR file.
  always_comb begin
    byp_hit = gpr_wen & (gpr_wa == byp_ra) & (byp_ra != '0);
    byp_wd  = gpr_wd;
  end
`endif

endmodule

// File: tb/tb_exu_gpr_wb_arb.sv
// Self-checking bench for exu_gpr_wb_arb: a reference grant model drives a
// scoreboard of expected write-stage contents, checked one cycle later.
module tb_exu_gpr_wb_arb;

  localparam int N    = 3;
  localparam int AW   = 5;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            wen;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
  } wr_t;

  logic                 clk;
  logic                 rst;
  logic                 stall;
  logic [N-1:0]         req_vld;
  logic [N*AW-1:0]      req_wa;
  logic [N*XLEN-1:0]    req_wd;
  logic [N-1:0]         req_rdy;
  logic                 gpr_wen;
  logic [AW-1:0]        gpr_wa;
  logic [XLEN-1:0]      gpr_wd;
  logic                 busy;
`ifdef EXU_GPR_WB_BYPASS_EN
  logic [AW-1:0]        byp_ra;
  logic                 byp_hit;
  logic [XLEN-1:0]      byp_wd;
`endif

  int  checks = 0;
  int  errors = 0;
  int  mptr   = 0;
  wr_t sb[$];
  int  grant_log[$];

  exu_gpr_wb_arb #(.N_REQ(N), .XLEN(XLEN), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .req_vld (req_vld),
    .req_wa  (req_wa),
    .req_wd  (req_wd),
    .req_rdy (req_rdy),
    .gpr_wen (gpr_wen),
    .gpr_wa  (gpr_wa),
    .gpr_wd  (gpr_wd),
    .busy    (busy)
`ifdef EXU_GPR_WB_BYPASS_EN
    ,
    .byp_ra  (byp_ra),
    .byp_hit (byp_hit),
    .byp_wd  (byp_wd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d);
    req_vld[i]            = v;
    req_wa[i*AW +: AW]    = a;
    req_wd[i*XLEN +: XLEN] = d;
  endtask

  // One clock: check the write stage against the scoreboard, check the grant
  // against the model, then push what the stage should hold next cycle.
  task automatic cycle();
    wr_t          e;
    wr_t          nx;
    logic [N-1:0] er;
    int           g;
    int           idx;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("gpr_wen", 64'(gpr_wen), 64'(e.wen));
    chk("gpr_wa",  64'(gpr_wa),  64'(e.wa));
    chk("gpr_wd",  64'(gpr_wd),  64'(e.wd));
    er = '0;
    g  = -1;
    if (!rst && !stall) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && req_vld[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(er));
    chk("busy", 64'(busy), 64'((|req_vld) | e.wen));
    if (rst) begin
      nx   = '0;
      mptr = 0;
    end else if (g >= 0) begin
      nx.wa  = req_wa[g*AW +: AW];
      nx.wd  = req_wd[g*XLEN +: XLEN];
      nx.wen = (nx.wa != '0);
      mptr   = (g + 1) % N;
      grant_log.push_back(g);
    end else begin
      nx     = e;
      nx.wen = 1'b0;
    end
    sb.push_back(nx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[6];
    rst     = 1'b1;
    stall   = 1'b0;
    req_vld = '1;
    req_wa  = '0;
    req_wd  = '0;
`ifdef EXU_GPR_WB_BYPASS_EN
    byp_ra  = '0;
`endif
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(10 + i), XLEN'(32'hA000 + i));

    // 1: reset with all valid -> no grants, stage cleared; req0 wins after release
    @(posedge clk);
    #1;
    sb.push_back('0);
    cycle();
    rst = 1'b0;
    grant_log.delete();
    cycle();
    chk("first_grant_after_reset", 64'(grant_log.size() == 1 ? grant_log[0] : -1), 64'd0);
    req_vld = '0;
    cycle();

    // 2: single write from req1
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    req_vld = '0;
    cycle();
    chk("single_wen", 64'(gpr_wen), 64'd0);
    cycle();

    // 3: fairness, all held valid for 6 cycles from a fresh pointer
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd3, 32'h11110000);
    set_req(1, 1'b1, 5'd3, 32'h22220000);
    set_req(2, 1'b1, 5'd4, 32'h33330000);
    grant_log.delete();
    for (int c = 0; c < 6; c++) cycle();
    req_vld = '0;
    exp_seq = '{0, 1, 2, 0, 1, 2};
    for (int c = 0; c < 6; c++)
      chk("rr_order", 64'(c < grant_log.size() ? grant_log[c] : -1), 64'(exp_seq[c]));
    cycle();

    // 4: x0 write then stall with req2 pending
    set_req(0, 1'b1, 5'd0, 32'hCAFEF00D);
    cycle();
    req_vld = '0;
    set_req(2, 1'b1, 5'd17, 32'h0BADC0DE);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    stall = 1'b0;
    grant_log.delete();
    cycle();
    chk("grant_after_stall", 64'(grant_log.size() == 1 ? grant_log[0] : -1), 64'd2);
    req_vld = '0;
    // stall while a write sits in the stage: it still retires
    stall = 1'b1;
    cycle();
    stall = 1'b0;
    cycle();

    // 5: reset right after a handshake drops the pending write
    set_req(1, 1'b1, 5'd9, 32'h99999999);
    cycle();
    req_vld = '0;
    rst = 1'b1;
    set_req(1, 1'b1, 5'd12, 32'h12121212);
    cycle();
    rst = 1'b0;
    req_vld = '1;
    grant_log.delete();
    cycle();
    chk("grant_after_midop_reset", 64'(grant_log.size() == 1 ? grant_log[0] : -1), 64'd0);
    req_vld = '0;
    cycle();

`ifdef EXU_GPR_WB_BYPASS_EN
    // 6: bypass lookup while the stage holds wa=7
    set_req(mptr, 1'b1, 5'd7, 32'h1234);
    cycle();
    req_vld = '0;
    byp_ra = 5'd7;
    #1;
    chk("byp_hit_7", 64'(byp_hit), 64'd1);
    chk("byp_wd_7", 64'(byp_wd), 64'h1234);
    byp_ra = 5'd0;
    #1;
    chk("byp_hit_0", 64'(byp_hit), 64'd0);
    byp_ra = 5'd8;
    #1;
    chk("byp_hit_8", 64'(byp_hit), 64'd0);
    cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
